// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with starvation guard, lock and registered read response
// Port 0 (MEM stage) has priority; port 1 is guaranteed a slot after STARVE_MAX denied cycles.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int               CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              sel0, sel1;
  logic              gnt0, gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Selection depends only on state and requests; grants are gated by reset so nothing leaks out while rst_n is low.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (p1_req && (!p0_req || starve_q == CNT_MAX)) begin
          sel1 = 1'b1;
        end else if (p0_req) begin
          sel0 = 1'b1;
        end
      end
      OWN0:    sel0 = 1'b1;
      OWN1:    sel1 = 1'b1;
      default: begin
        sel0 = 1'b0;
        sel1 = 1'b0;
      end
    endcase
    gnt0 = rst_n && p0_req && sel0;
    gnt1 = rst_n && p1_req && sel1;
  end

  // Ownership release takes effect at the next edge, so the owner may still be granted in its unlock cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt0 && p0_lock) begin
          state_d = OWN0;
        end else if (gnt1 && p1_lock) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!p0_lock) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (!p1_lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt1) begin
      starve_d = '0;
    end else if (p1_req && starve_q != CNT_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (gnt0) begin
      mem_access_addr = p0_addr;
      mem_write_data  = p0_wdata;
      mem_write_en    = p0_we;
      mem_read        = !p0_we;
    end else if (gnt1) begin
      mem_access_addr = p1_addr;
      mem_write_data  = p1_wdata;
      mem_write_en    = p1_we;
      mem_read        = !p1_we;
    end
  end

  // Read data is captured at the edge ending the grant cycle and held until the next read on that port.
  always_comb begin
    rvalid0_d = gnt0 && !p0_we;
    rvalid1_d = gnt1 && !p1_we;
    rdata0_d  = rvalid0_d ? mem_read_data : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_read_data : rdata1_q;
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p0_we, p0_lock;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt, p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req, p1_we, p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt, p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en, mem_read;
  logic [DATA_W-1:0] mem_read_data;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] mem_model [0:255];
  logic [DATA_W-1:0] exp_mem [0:255];

  always #5 clk = ~clk;

  assign mem_read_data = mem_model[mem_access_addr[7:0]];

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  function automatic logic [DATA_W-1:0] pat(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic memory_writer();
    forever begin
      @(posedge clk);
      if (mem_write_en) mem_model[mem_access_addr[7:0]] = mem_write_data;
    end
  endtask

  task automatic rvalid_monitor();
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (p0_rvalid) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL p0_rvalid_unexpected: got rvalid with rdata=%h, required no rvalid", p0_rdata);
        end else begin
          e = q0.pop_front();
          if (p0_rdata !== e) begin
            errors++;
            $display("FAIL p0_rdata_sb: got %h, required %h", p0_rdata, e);
          end
        end
      end
      if (p1_rvalid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL p1_rvalid_unexpected: got rvalid with rdata=%h, required no rvalid", p1_rdata);
        end else begin
          e = q1.pop_front();
          if (p1_rdata !== e) begin
            errors++;
            $display("FAIL p1_rdata_sb: got %h, required %h", p1_rdata, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h44; p0_wdata = 32'h1234_5678;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h45; p1_wdata = 32'h8765_4321;
    @(negedge clk);
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b, required 00", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_write_en, mem_read} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b, required 00", {mem_write_en, mem_read}); end
    checks++; if (mem_access_addr !== '0 || mem_write_data !== '0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h data=%h, required 0", mem_access_addr, mem_write_data); end
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b, required 00", {p0_rvalid, p1_rvalid}); end
    checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h, required 0", p0_rdata, p1_rdata); end
    @(posedge clk); #1;
    p0_we = 1'b0; p1_we = 1'b0; p0_addr = 32'h40; p1_addr = 32'h41;
    q0.push_back(exp_mem[8'h40]);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL first_gnt: got %b, required 10", {p0_gnt, p1_gnt}); end
    checks++; if (mem_read !== 1'b1 || mem_access_addr !== 32'h40) begin errors++; $display("FAIL first_mem: got rd=%b addr=%h, required 1/40", mem_read, mem_access_addr); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== pat(32'h40)) begin errors++; $display("FAIL first_read: got rvalid=%b rdata=%h, required 1/%h", p0_rvalid, p0_rdata, pat(32'h40)); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    apply_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEAD_BEEF;
    exp_mem[8'h10] = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || mem_write_en !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_ctrl: got gnt=%b we=%b rd=%b, required 1/1/0", p0_gnt, mem_write_en, mem_read); end
    checks++; if (mem_access_addr !== 32'h10 || mem_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_bus: got %h/%h, required 10/deadbeef", mem_access_addr, mem_write_data); end
    @(posedge clk); #1;
    p0_we = 1'b0;
    q0.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write_en !== 1'b0) begin errors++; $display("FAIL rd_ctrl: got gnt=%b rd=%b we=%b, required 1/1/0", p0_gnt, mem_read, mem_write_en); end
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early: got rvalid=%b, required 0", p0_rvalid); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_resp: got %b/%h, required 1/deadbeef", p0_rvalid, p0_rdata); end
    checks++; if (mem_read !== 1'b0 || mem_access_addr !== '0) begin errors++; $display("FAIL idle_bus: got rd=%b addr=%h, required 0/0", mem_read, mem_access_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold: got %b/%h, required 0/deadbeef", p0_rvalid, p0_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      a = 8'h10 + 8'(i);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = {24'h0, a};
      q0.push_back(exp_mem[a]);
      @(negedge clk);
      checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b, required 1", i, p0_gnt); end
      if (i > 0) begin
        checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b, required 1", i, p0_rvalid); end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b, required 1", p0_rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic [7:0] a0, a1;
    logic       e1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      a0 = 8'h30 + 8'(i);
      a1 = 8'h50 + 8'(i);
      e1 = ((i % 5) == 4);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = {24'h0, a0};
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = {24'h0, a1};
      if (e1) q1.push_back(exp_mem[a1]);
      else    q0.push_back(exp_mem[a0]);
      @(negedge clk);
      checks++; if ({p0_gnt, p1_gnt} !== {!e1, e1}) begin errors++; $display("FAIL starve_gnt[%0d]: got %b, required %b", i, {p0_gnt, p1_gnt}, {!e1, e1}); end
      checks++; if (mem_access_addr !== {24'h0, (e1 ? a1 : a0)}) begin errors++; $display("FAIL starve_addr[%0d]: got %h, required %h", i, mem_access_addr, (e1 ? a1 : a0)); end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_p1_lock();
    logic [5:0] v_p1r, v_p1l, v_p0r, v_e0, v_e1;
    logic [7:0] a1;
    apply_reset();
    v_p1r = 6'b000111; v_p1l = 6'b001111; v_p0r = 6'b111110;
    v_e0  = 6'b100000; v_e1  = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      a1 = 8'h20 + 8'(i);
      p1_req = v_p1r[i]; p1_lock = v_p1l[i]; p1_we = 1'b0; p1_addr = {24'h0, a1};
      p0_req = v_p0r[i]; p0_lock = 1'b0; p0_we = 1'b0; p0_addr = 32'h60;
      if (v_e1[i]) q1.push_back(exp_mem[a1]);
      if (v_e0[i]) q0.push_back(exp_mem[8'h60]);
      @(negedge clk);
      checks++; if ({p0_gnt, p1_gnt} !== {v_e0[i], v_e1[i]}) begin errors++; $display("FAIL p1lock_gnt[%0d]: got %b, required %b", i, {p0_gnt, p1_gnt}, {v_e0[i], v_e1[i]}); end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_lock_starve();
    logic [8:0] v_p0r, v_p0l, v_p1r, v_e0, v_e1;
    logic [7:0] a0, a1;
    apply_reset();
    v_p0r = 9'b111111111; v_p0l = 9'b000111111; v_p1r = 9'b011111111;
    v_e0  = 9'b101111111; v_e1  = 9'b010000000;
    for (int i = 0; i < 9; i++) begin
      a0 = 8'h00 + 8'(i);
      a1 = 8'h90 + 8'(i);
      p0_req = v_p0r[i]; p0_lock = v_p0l[i]; p0_we = 1'b0; p0_addr = {24'h0, a0};
      p1_req = v_p1r[i]; p1_lock = 1'b0;     p1_we = 1'b0; p1_addr = {24'h0, a1};
      if (v_e0[i]) q0.push_back(exp_mem[a0]);
      if (v_e1[i]) q1.push_back(exp_mem[a1]);
      @(negedge clk);
      checks++; if ({p0_gnt, p1_gnt} !== {v_e0[i], v_e1[i]}) begin errors++; $display("FAIL lockstarve_gnt[%0d]: got %b, required %b", i, {p0_gnt, p1_gnt}, {v_e0[i], v_e1[i]}); end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    p0_req = 1'b1; p0_lock = 1'b1; p0_we = 1'b0; p0_addr = 32'h70;
    q0.push_back(exp_mem[8'h70]);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL midlock_gnt0: got %b, required 1", p0_gnt); end
    @(posedge clk); #1;
    p0_addr = 32'h71;
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL midlock_gnt1: got %b, required 1", p0_gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (p0_gnt !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL midlock_rst_gate: got gnt=%b rd=%b, required 0/0", p0_gnt, mem_read); end
    @(posedge clk); #1;
    idle_inputs();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h80;
    q1.push_back(exp_mem[8'h80]);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL midlock_no_rvalid: got %b, required 0", p0_rvalid); end
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL midlock_p1_gnt: got %b, required 01", {p0_gnt, p1_gnt}); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0) begin errors++; $display("FAIL midlock_p1_resp: got p1=%b p0=%b, required 1/0", p1_rvalid, p0_rvalid); end
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = pat(i);
      exp_mem[i]   = pat(i);
    end
    fork
      memory_writer();
      rvalid_monitor();
    join_none
    test_reset();
    test_write_read();
    test_back_to_back();
    test_starvation();
    test_p1_lock();
    test_lock_starve();
    test_reset_mid_lock();
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d pending reads, required 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
